// File: rtl/led_seq_mgr_pkg.sv
// Shared definitions for the LED sequencer: command layout, opcodes,
// shift-mode bit positions and FSM state encoding.
package led_seq_mgr_pkg;

  // LED ops (DEV_ADDR)
  localparam logic [2:0] DEV_NOP = 3'b000;
  localparam logic [2:0] DEV_TGL = 3'b001;
  localparam logic [2:0] DEV_SHL = 3'b010;
  localparam logic [2:0] DEV_SHR = 3'b011;
  localparam logic [2:0] DEV_OFF = 3'b100;
  localparam logic [2:0] DEV_ON  = 3'b101;
  localparam logic [2:0] DEV_RST = 3'b110;
  localparam logic [2:0] DEV_SET = 3'b111;

  // Config ops (CFG_ADDR)
  localparam logic [2:0] CFG_STOP    = 3'b000;
  localparam logic [2:0] CFG_AUTO_L  = 3'b001;
  localparam logic [2:0] CFG_AUTO_R  = 3'b010;
  localparam logic [2:0] CFG_PERIOD  = 3'b011;
  localparam logic [2:0] CFG_BLK_OFF = 3'b100;
  localparam logic [2:0] CFG_BLK_ON  = 3'b101;
  localparam logic [2:0] CFG_BLK_CLR = 3'b110;
  localparam logic [2:0] CFG_BLK_ALL = 3'b111;

  // Shift mode fields within d: rotate select and fill value
  localparam int SM_ROT  = 3;
  localparam int SM_FILL = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO_L = 2'd1,
    ST_AUTO_R = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [2:0] op;
    logic [3:0] d;
  } cmd_t;

endpackage

// File: rtl/led_seq_mgr_if.sv
// Command bus into the LED sequencer.
//   new_cmd : single-cycle strobe, cmd_buf valid
//   cmd_buf : {addr[4:0], op[2:0], d[3:0]}
interface led_seq_mgr_if;
  logic        new_cmd;
  logic [11:0] cmd_buf;

  modport master (output new_cmd, output cmd_buf);
  modport slave  (input  new_cmd, input  cmd_buf);
endinterface

// File: rtl/led_seq_mgr_tick_gen.sv
// Timebase for the LED sequencer: prescaler producing a base tick every
// PRESCALE clocks, and a period counter producing a one-cycle step strobe
// every `period` ticks. blink_phase toggles on each step.
//   clk, rst_n  : clock, async active-low reset
//   period      : ticks per step, 1..16
//   reload      : restart both counters (period was just rewritten)
//   step        : one-cycle strobe at period terminal count
//   blink_phase : toggles on each step
module led_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] period,
  input  logic       reload,
  output logic       step,
  output logic       blink_phase
);
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;
  logic [4:0]    per_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));
  // A reload in the same cycle cancels the step so the new period starts clean
  assign step = tick && (per_cnt == period - 5'd1) && !reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      per_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (reload) begin
      pre_cnt <= '0;
      per_cnt <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        per_cnt <= step ? 5'd0 : per_cnt + 5'd1;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
      if (step) blink_phase <= ~blink_phase;
    end
  end
endmodule

// File: rtl/led_seq_mgr.sv
// LED manager: decodes bus commands into an LED state register, runs an
// autonomous chaser (AUTO_L/AUTO_R) and per-LED blinking off a shared timebase.
//   clk, rst_n  : clock, async active-low reset
//   bus         : command bus (slave)
//   leds        : led_state ^ (blink_en & blink_phase)
//   auto_active : high in AUTO_L / AUTO_R
module led_seq_mgr
  import led_seq_mgr_pkg::*;
#(
  parameter int         N_LEDS   = 10,
  parameter logic [4:0] DEV_ADDR = 5'h0C,
  parameter logic [4:0] CFG_ADDR = 5'h0D,
  parameter int         PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  led_seq_mgr_if.slave      bus,
  output logic [N_LEDS-1:0] leds,
  output logic              auto_active
);
  cmd_t              cmd;
  logic              dev_hit, cfg_hit, reload, step, blink_phase;
  logic [N_LEDS-1:0] led_state, blink_en, mask;
  logic [N_LEDS-1:0] shl_c, shr_c, shl_a, shr_a;
  logic              lin_c, rin_c, lin_a, rin_a;
  logic [4:0]        period;
  logic              sm_rot, sm_fill;
  state_t            state;

  assign cmd     = cmd_t'(bus.cmd_buf);
  assign dev_hit = bus.new_cmd && (cmd.addr == DEV_ADDR);
  assign cfg_hit = bus.new_cmd && (cmd.addr == CFG_ADDR);
  assign reload  = cfg_hit && (cmd.op == CFG_PERIOD);

  // One-hot of d; indices beyond the LED count decode to an empty mask
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_LEDS; i++)
      if (cmd.d == 4'(i)) mask[i] = 1'b1;
  end

  // Bit shifted in: wrapped bit when rotating, otherwise the fill value.
  // _c variants use the command's d, _a variants the latched auto mode.
  assign lin_c = cmd.d[SM_ROT] ? led_state[N_LEDS-1] : cmd.d[SM_FILL];
  assign rin_c = cmd.d[SM_ROT] ? led_state[0]        : cmd.d[SM_FILL];
  assign lin_a = sm_rot        ? led_state[N_LEDS-1] : sm_fill;
  assign rin_a = sm_rot        ? led_state[0]        : sm_fill;

  generate
    if (N_LEDS == 1) begin : g_one
      // Single LED: rotate holds, fill loads the fill bit
      assign shl_c = lin_c;
      assign shr_c = rin_c;
      assign shl_a = lin_a;
      assign shr_a = rin_a;
    end else begin : g_multi
      assign shl_c = {led_state[N_LEDS-2:0], lin_c};
      assign shr_c = {rin_c, led_state[N_LEDS-1:1]};
      assign shl_a = {led_state[N_LEDS-2:0], lin_a};
      assign shr_a = {rin_a, led_state[N_LEDS-1:1]};
    end
  endgenerate

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .period      (period),
    .reload      (reload),
    .step        (step),
    .blink_phase (blink_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_state   <= '0;
      blink_en    <= '0;
      period      <= 5'd1;
      sm_rot      <= 1'b0;
      sm_fill     <= 1'b0;
      state       <= ST_IDLE;
      auto_active <= 1'b0;
    end else begin
      // A bus write to the LEDs takes priority; a coincident auto step is lost
      if (dev_hit) begin
        case (cmd.op)
          DEV_NOP: ;
          DEV_TGL: led_state <= led_state ^ mask;
          DEV_SHL: led_state <= shl_c;
          DEV_SHR: led_state <= shr_c;
          DEV_OFF: led_state <= led_state & ~mask;
          DEV_ON:  led_state <= led_state | mask;
          DEV_RST: led_state <= '0;
          DEV_SET: led_state <= '1;
        endcase
      end else if (step) begin
        case (state)
          ST_AUTO_L: led_state <= shl_a;
          ST_AUTO_R: led_state <= shr_a;
          default:   ;
        endcase
      end

      if (cfg_hit) begin
        case (cmd.op)
          CFG_STOP: begin
            state       <= ST_IDLE;
            auto_active <= 1'b0;
          end
          CFG_AUTO_L: begin
            state       <= ST_AUTO_L;
            auto_active <= 1'b1;
            sm_rot      <= cmd.d[SM_ROT];
            sm_fill     <= cmd.d[SM_FILL];
          end
          CFG_AUTO_R: begin
            state       <= ST_AUTO_R;
            auto_active <= 1'b1;
            sm_rot      <= cmd.d[SM_ROT];
            sm_fill     <= cmd.d[SM_FILL];
          end
          CFG_PERIOD:  period   <= {1'b0, cmd.d} + 5'd1;
          CFG_BLK_OFF: blink_en <= blink_en & ~mask;
          CFG_BLK_ON:  blink_en <= blink_en | mask;
          CFG_BLK_CLR: blink_en <= '0;
          CFG_BLK_ALL: blink_en <= '1;
        endcase
      end
    end
  end

  assign leds = led_state ^ (blink_en & {N_LEDS{blink_phase}});
endmodule

// File: tb/tb_led_seq_mgr.sv
module tb_led_seq_mgr;
  localparam logic [4:0] DEV = 5'h0C;
  localparam logic [4:0] CFG = 5'h0D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] leds;
  logic       auto_active;

  led_seq_mgr_if bus ();

  led_seq_mgr #(.N_LEDS(10), .DEV_ADDR(DEV), .CFG_ADDR(CFG), .PRESCALE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .leds        (leds),
    .auto_active (auto_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [2:0] op;
    logic [3:0] d;
    logic [9:0] exp;
  } vec_t;

  int         n_vec = 0;
  int         n_miss = 0;
  logic [9:0] exp_q[$];
  vec_t       vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one command and returns at the next negedge,
  // after the capturing posedge.
  task automatic send(input logic [4:0] a, input logic [2:0] op, input logic [3:0] d);
    bus.new_cmd = 1'b1;
    bus.cmd_buf = {a, op, d};
    @(negedge clk);
    bus.new_cmd = 1'b0;
    bus.cmd_buf = '0;
  endtask

  task automatic wait_change(input int limit, output int cyc, output logic ok);
    logic [9:0] prev;
    prev = leds;
    cyc  = 0;
    ok   = 1'b0;
    while (cyc < limit && !ok) begin
      @(negedge clk);
      cyc++;
      if (leds !== prev) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    logic       ok;
    logic [9:0] e;
    logic [9:0] prev;
    logic       stayed;

    vecs[0]  = '{DEV,   3'b101, 4'd3,     10'h008};  // ON 3
    vecs[1]  = '{DEV,   3'b101, 4'd9,     10'h208};  // ON 9
    vecs[2]  = '{DEV,   3'b101, 4'd12,    10'h208};  // ON out of range
    vecs[3]  = '{5'h05, 3'b101, 4'd0,     10'h208};  // foreign address
    vecs[4]  = '{DEV,   3'b001, 4'd3,     10'h200};  // TGL 3
    vecs[5]  = '{DEV,   3'b100, 4'd9,     10'h000};  // OFF 9
    vecs[6]  = '{DEV,   3'b111, 4'd0,     10'h3FF};  // SET
    vecs[7]  = '{DEV,   3'b010, 4'b0000,  10'h3FE};  // SHL fill 0
    vecs[8]  = '{DEV,   3'b011, 4'b0001,  10'h3FF};  // SHR fill 1
    vecs[9]  = '{DEV,   3'b110, 4'd0,     10'h000};  // RST
    vecs[10] = '{DEV,   3'b101, 4'd9,     10'h200};  // ON 9
    vecs[11] = '{DEV,   3'b010, 4'b1000,  10'h001};  // SHL rotate
    vecs[12] = '{DEV,   3'b011, 4'b1000,  10'h200};  // SHR rotate
    vecs[13] = '{DEV,   3'b011, 4'b0000,  10'h100};  // SHR fill 0
    vecs[14] = '{DEV,   3'b000, 4'd5,     10'h100};  // NOP

    rst_n       = 1'b0;
    bus.new_cmd = 1'b0;
    bus.cmd_buf = '0;
    repeat (3) @(negedge clk);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_auto", 32'(auto_active), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single commands through the scoreboard queue
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(vecs[i].exp);
      send(vecs[i].a, vecs[i].op, vecs[i].d);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), 32'(leds), 32'(e));
      check($sformatf("vec%0d_auto", i), 32'(auto_active), 32'h0);
    end

    // Chaser: rotate left every 2 ticks = 8 clocks
    send(DEV, 3'b110, 4'd0);
    send(DEV, 3'b101, 4'd0);
    check("chase_init", 32'(leds), 32'h001);
    send(CFG, 3'b011, 4'd1);
    send(CFG, 3'b001, 4'b1000);
    check("chase_auto_on", 32'(auto_active), 32'h1);
    e = 10'h001;
    for (int k = 1; k <= 10; k++) begin
      wait_change(20, cyc, ok);
      check($sformatf("chase_step%0d_seen", k), 32'(ok), 32'h1);
      e = {e[8:0], e[9]};
      check($sformatf("chase_step%0d", k), 32'(leds), 32'(e));
      if (k > 1) check($sformatf("chase_step%0d_gap", k), 32'(cyc), 32'd8);
    end
    send(CFG, 3'b000, 4'd0);
    check("chase_auto_off", 32'(auto_active), 32'h0);
    repeat (20) @(negedge clk);
    check("chase_frozen", 32'(leds), 32'h001);

    // Blink LED0 with period 1 tick = 4 clocks
    send(DEV, 3'b110, 4'd0);
    send(CFG, 3'b011, 4'd0);
    send(CFG, 3'b101, 4'd0);
    wait_change(10, cyc, ok);
    check("blink_seen", 32'(ok), 32'h1);
    for (int k = 0; k < 3; k++) begin
      prev = leds;
      wait_change(10, cyc, ok);
      check($sformatf("blink%0d_gap", k), 32'(cyc), 32'd4);
      check($sformatf("blink%0d_val", k), 32'(leds), 32'(prev ^ 10'h001));
    end
    send(CFG, 3'b110, 4'd0);
    check("blink_off", 32'(leds), 32'h0);

    // Collision: TGL on the step cycle wins, the shift is dropped
    send(DEV, 3'b101, 4'd0);
    send(CFG, 3'b011, 4'd0);
    send(CFG, 3'b010, 4'b1000);
    wait_change(10, cyc, ok);
    check("coll_first_seen", 32'(ok), 32'h1);
    check("coll_first", 32'(leds), 32'h200);
    repeat (3) @(negedge clk);
    send(DEV, 3'b001, 4'd5);
    check("coll_tgl_wins", 32'(leds), 32'h220);
    wait_change(10, cyc, ok);
    check("coll_next_gap", 32'(cyc), 32'd4);
    check("coll_next", 32'(leds), 32'h110);
    send(CFG, 3'b000, 4'd0);

    // Async reset mid-chase with blinking
    send(DEV, 3'b110, 4'd0);
    send(DEV, 3'b101, 4'd0);
    send(CFG, 3'b111, 4'd0);
    send(CFG, 3'b001, 4'b1000);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_leds", 32'(leds), 32'h0);
    check("areset_auto", 32'(auto_active), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    stayed = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (leds !== 10'h0 || auto_active !== 1'b0) stayed = 1'b0;
    end
    check("post_reset_idle", 32'(stayed), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
